// File: rtl/sched_operand_sequencer_pkg.sv
// Shared definitions for the scheduled datapath job sequencer: state encoding
// and the default word width, operand count and watchdog limit.
package sched_operand_sequencer_pkg;

  typedef enum logic [2:0] {
    S_FILL  = 3'd0,
    S_DRAIN = 3'd1,
    S_ISSUE = 3'd2,
    S_RUN   = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_NUM_OPS = 3;
  localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/sched_operand_sequencer_watchdog.sv
// Run watchdog: counts enabled cycles from a clear and flags expiry once the
// count reaches TIMEOUT; the count saturates there until the next clear.
module sched_watchdog
  import sched_operand_sequencer_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);

  logic [TO_W-1:0] cnt_r;

  // Cycle counter with clear priority and saturation at the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en && (cnt_r != LIMIT)) begin
      cnt_r <= cnt_r + TO_W'(1);
    end
  end

  assign expired = (cnt_r == LIMIT);

endmodule

// File: rtl/sched_operand_sequencer.sv
// Job sequencer: gathers one operand frame, starts the controller, waits for
// the datapath result and hands it downstream, guarded by a run watchdog.
module sched_operand_sequencer
  import sched_operand_sequencer_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NUM_OPS = DEF_NUM_OPS,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [NUM_OPS*DATA_W-1:0] op_data,
  input  logic                      op_ready,
  output logic                      start,
  input  logic                      done,
  input  logic [DATA_W-1:0]         result,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      err_frame,
  output logic                      err_timeout
);

  localparam int CNT_W = $clog2(NUM_OPS);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_OPS - 1);

  state_t                      state_r, state_s;
  logic [CNT_W-1:0]            idx_r, idx_s;
  logic [NUM_OPS*DATA_W-1:0]   op_data_r;
  logic [DATA_W-1:0]           out_data_r;
  logic                        out_valid_r, out_valid_s;
  logic                        err_frame_r, err_frame_s;
  logic                        err_timeout_r, err_timeout_s;
  logic                        wr_en_s, capture_s, in_ready_s, start_s;
  logic                        wd_clr_s, wd_en_s, wd_expired_s;

  sched_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr_s),
    .en      (wd_en_s),
    .expired (wd_expired_s)
  );

  // Next-state, frame bookkeeping and control strobes
  always_comb begin
    state_s       = state_r;
    idx_s         = idx_r;
    out_valid_s   = out_valid_r;
    wr_en_s       = 1'b0;
    capture_s     = 1'b0;
    err_frame_s   = 1'b0;
    err_timeout_s = 1'b0;
    in_ready_s    = 1'b0;
    start_s       = 1'b0;
    wd_clr_s      = 1'b0;
    wd_en_s       = 1'b0;
    case (state_r)
      S_FILL: begin
        in_ready_s = 1'b1;
        if (in_valid) begin
          wr_en_s = 1'b1;
          if (idx_r == LAST_IDX) begin
            idx_s = '0;
            if (in_last) begin
              state_s = S_ISSUE;
            end else begin
              // Overlong frame: the tail is swallowed in S_DRAIN
              err_frame_s = 1'b1;
              state_s     = S_DRAIN;
            end
          end else if (in_last) begin
            err_frame_s = 1'b1;
            idx_s       = '0;
          end else begin
            idx_s = idx_r + CNT_W'(1);
          end
        end else begin
          idx_s = idx_r;
        end
      end
      S_DRAIN: begin
        in_ready_s = 1'b1;
        if (in_valid && in_last) begin
          state_s = S_FILL;
        end else begin
          state_s = S_DRAIN;
        end
      end
      S_ISSUE: begin
        start_s = op_ready;
        if (op_ready) begin
          wd_clr_s = 1'b1;
          state_s  = S_RUN;
        end else begin
          state_s = S_ISSUE;
        end
      end
      S_RUN: begin
        wd_en_s = 1'b1;
        if (done) begin
          capture_s   = 1'b1;
          out_valid_s = 1'b1;
          state_s     = S_OUT;
        end else if (wd_expired_s) begin
          err_timeout_s = 1'b1;
          state_s       = S_FILL;
        end else begin
          state_s = S_RUN;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_s = 1'b0;
          state_s     = S_FILL;
        end else begin
          state_s = S_OUT;
        end
      end
      default: begin
        state_s     = S_FILL;
        idx_s       = '0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // State, index, result and error-pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= S_FILL;
      idx_r         <= '0;
      out_valid_r   <= 1'b0;
      out_data_r    <= '0;
      err_frame_r   <= 1'b0;
      err_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      idx_r         <= idx_s;
      out_valid_r   <= out_valid_s;
      err_frame_r   <= err_frame_s;
      err_timeout_r <= err_timeout_s;
      if (capture_s) begin
        out_data_r <= result;
      end
    end
  end

  // Operand word registers, written only while filling
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_data_r <= '0;
    end else begin
      for (int k = 0; k < NUM_OPS; k++) begin
        if (wr_en_s && (idx_r == CNT_W'(k))) begin
          op_data_r[k*DATA_W +: DATA_W] <= in_data;
        end
      end
    end
  end

  assign in_ready    = in_ready_s;
  assign start       = start_s;
  assign busy        = (state_r != S_FILL);
  assign op_data     = op_data_r;
  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign err_frame   = err_frame_r;
  assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_sched_operand_sequencer.sv
// Directed bench for sched_operand_sequencer: frame capture, start timing,
// result return with back-pressure, frame errors, watchdog and async reset.
module tb_sched_operand_sequencer;

  localparam int DW = 16;
  localparam int NO = 3;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_last, in_ready;
  logic [DW-1:0]   in_data;
  logic [NO*DW-1:0] op_data;
  logic            op_ready, start, done;
  logic [DW-1:0]   result;
  logic            out_valid, out_ready;
  logic [DW-1:0]   out_data;
  logic            busy, err_frame, err_timeout;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  sched_operand_sequencer #(.DATA_W(DW), .NUM_OPS(NO), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .op_data(op_data), .op_ready(op_ready), .start(start),
    .done(done), .result(result),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .err_frame(err_frame), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [DW-1:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_done(input logic [DW-1:0] r, input logic expect_out);
    done   = 1'b1;
    result = r;
    if (expect_out) exp_q.push_back(r);
    step();
    done = 1'b0;
  endtask

  // Wait (bounded) for out_valid and compare against the scoreboard head
  task automatic expect_result(input string tag);
    int n = 0;
    logic [DW-1:0] e;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"}, {48'd0, out_data}, {48'd0, e});
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    op_ready = 1'b0; done = 1'b0; result = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_op_data", {16'd0, op_data}, 64'd0);
    check("rst_out_data", {48'd0, out_data}, 64'd0);
    check("rst_errs", {62'd0, err_frame, err_timeout}, 64'd0);

    // Normal job
    op_ready = 1'b1;
    send_word(16'h0003, 1'b0);
    check("norm_nostart", {63'd0, start}, 64'd0);
    send_word(16'h0005, 1'b0);
    send_word(16'h0007, 1'b1);
    check("norm_start", {63'd0, start}, 64'd1);
    check("norm_in_ready_issue", {63'd0, in_ready}, 64'd0);
    check("norm_op_data", {16'd0, op_data}, {16'd0, 16'h0007, 16'h0005, 16'h0003});
    step();
    check("norm_start_once", {63'd0, start}, 64'd0);
    check("norm_busy_run", {63'd0, busy}, 64'd1);
    step(); step(); step();
    check("norm_op_stable", {16'd0, op_data}, {16'd0, 16'h0007, 16'h0005, 16'h0003});
    pulse_done(16'h0042, 1'b1);
    expect_result("norm_out");
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("norm_out_cleared", {63'd0, out_valid}, 64'd0);
    check("norm_busy_idle", {63'd0, busy}, 64'd0);
    check("norm_in_ready_idle", {63'd0, in_ready}, 64'd1);

    // Back-pressure on the result stream
    send_word(16'h0003, 1'b0);
    send_word(16'h0005, 1'b0);
    send_word(16'h0007, 1'b1);
    step();
    pulse_done(16'h0042, 1'b1);
    expect_result("bp_out");
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_valid_hold", {63'd0, out_valid}, 64'd1);
      check("bp_data_hold", {48'd0, out_data}, 64'h42);
      check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_released", {63'd0, out_valid}, 64'd0);
    check("bp_in_ready_back", {63'd0, in_ready}, 64'd1);

    // Short frame, then a valid frame with new operands
    send_word(16'h1111, 1'b1);
    check("short_err", {63'd0, err_frame}, 64'd1);
    check("short_nostart", {63'd0, start}, 64'd0);
    check("short_busy", {63'd0, busy}, 64'd0);
    step();
    check("short_err_oneshot", {63'd0, err_frame}, 64'd0);
    send_word(16'h000A, 1'b0);
    send_word(16'h000B, 1'b0);
    send_word(16'h000C, 1'b1);
    check("short_next_start", {63'd0, start}, 64'd1);
    check("short_next_ops", {16'd0, op_data}, {16'd0, 16'h000C, 16'h000B, 16'h000A});
    step();
    pulse_done(16'h0099, 1'b1);
    expect_result("short_next_out");
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Long frame
    send_word(16'h0021, 1'b0);
    send_word(16'h0022, 1'b0);
    check("long_no_err_yet", {63'd0, err_frame}, 64'd0);
    send_word(16'h0023, 1'b0);
    check("long_err", {63'd0, err_frame}, 64'd1);
    check("long_drain_ready", {63'd0, in_ready}, 64'd1);
    check("long_drain_busy", {63'd0, busy}, 64'd1);
    send_word(16'h0024, 1'b1);
    check("long_err_oneshot", {63'd0, err_frame}, 64'd0);
    check("long_nostart", {63'd0, start}, 64'd0);
    check("long_ops_kept", {16'd0, op_data}, {16'd0, 16'h0023, 16'h0022, 16'h0021});
    check("long_back_fill", {63'd0, busy}, 64'd0);

    // Controller busy, then watchdog timeout
    op_ready = 1'b0;
    send_word(16'h0031, 1'b0);
    send_word(16'h0032, 1'b0);
    send_word(16'h0033, 1'b1);
    for (int i = 0; i < 20; i++) begin
      check("to_wait_nostart", {63'd0, start}, 64'd0);
      step();
    end
    op_ready = 1'b1;
    #1;
    check("to_start", {63'd0, start}, 64'd1);
    step();
    check("to_start_once", {63'd0, start}, 64'd0);
    n = 0;
    while (!err_timeout && n < 200) begin
      step();
      n++;
    end
    // Run entered at the previous edge; the watchdog reaches TO after TO
    // more edges and the abort registers on the one after that.
    check("to_cycles", 64'(n), 64'(TO + 1));
    check("to_pulse", {63'd0, err_timeout}, 64'd1);
    check("to_no_out", {63'd0, out_valid}, 64'd0);
    check("to_back_fill", {63'd0, busy}, 64'd0);
    step();
    check("to_pulse_oneshot", {63'd0, err_timeout}, 64'd0);

    // Async reset during a run
    send_word(16'h0041, 1'b0);
    send_word(16'h0042, 1'b0);
    send_word(16'h0043, 1'b1);
    step(); step();
    check("ar_busy_before", {63'd0, busy}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_busy", {63'd0, busy}, 64'd0);
    check("ar_in_ready", {63'd0, in_ready}, 64'd1);
    check("ar_op_data", {16'd0, op_data}, 64'd0);
    check("ar_start", {63'd0, start}, 64'd0);
    check("ar_errs", {62'd0, err_frame, err_timeout}, 64'd0);
    step();
    rst = 1'b0;
    step();
    pulse_done(16'h0077, 1'b0);
    check("ar_done_ignored", {63'd0, out_valid}, 64'd0);
    check("ar_out_data", {48'd0, out_data}, 64'd0);
    step();
    check("ar_still_idle", {62'd0, out_valid, busy}, 64'd0);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sched_operand_sequencer.md
Name: sched_operand_sequencer

Overview:
- Job-level front/back end for the scheduled datapath controller.
- Collects one operand frame from an upstream valid/ready stream into operand registers and presents them to the datapath input muxes.
- Starts the controller when it reports op_ready, waits for the datapath done pulse, captures the result and returns it on a valid/ready output stream.
- Single job in flight; a run watchdog guards against a hung schedule.

Parameters:
- DATA_W, 16, width of operand and result words
- NUM_OPS, 3, operand words per frame (mux sources 0..NUM_OPS-1); minimum 2
- TIMEOUT, 64, maximum cycles allowed in S_RUN before abort; minimum 8
- CNT_W (local), clog2(NUM_OPS), word index width
- TO_W (local), clog2(TIMEOUT+1), watchdog counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream operand word valid
- in_data  in  DATA_W  operand word
- in_last  in  1  marks final word of a frame
- in_ready  out  1  sequencer accepts a word this cycle
- op_data  out  NUM_OPS*DATA_W  operand registers; word k at bits [k*DATA_W +: DATA_W]
- op_ready  in  1  controller idle, can take start
- start  out  1  one-cycle start to controller
- done  in  1  datapath done pulse, result valid this cycle
- result  in  DATA_W  datapath result
- out_valid  out  1  result available
- out_data  out  DATA_W  captured result
- out_ready  in  1  downstream accepts result
- busy  out  1  high in every state except S_FILL
- err_frame  out  1  one-cycle pulse on a malformed frame
- err_timeout  out  1  one-cycle pulse on a watchdog abort

Behaviour:
- Reset: state=S_FILL, word index=0, watchdog=0, op_data=0, out_data=0; start, out_valid, err_frame and err_timeout are 0; in_ready=1 and busy=0 immediately after reset.
- A word transfers when in_valid && in_ready. in_ready=1 only in S_FILL and S_DRAIN.
- S_FILL, on transfer:
  - Write in_data to op_data word[idx].
  - If idx==NUM_OPS-1 && in_last: go to S_ISSUE, idx=0.
  - If in_last && idx<NUM_OPS-1 (short frame): pulse err_frame, idx=0, stay in S_FILL. Written words are stale; the next frame overwrites them.
  - If idx==NUM_OPS-1 && !in_last (long frame): pulse err_frame, idx=0, go to S_DRAIN.
  - Otherwise idx++.
- S_DRAIN: accept and discard words. On a transfer with in_last, go to S_FILL. op_data is not written.
- S_ISSUE:
  - in_ready=0, op_data stable.
  - start = op_ready, combinational, so it is high exactly one cycle.
  - On op_ready=1, go to S_RUN and clear the watchdog. Otherwise wait indefinitely.
- S_RUN:
  - op_data held stable for the whole run. The watchdog increments every cycle.
  - On done=1: out_data<=result, out_valid<=1, go to S_OUT.
  - If the watchdog reaches TIMEOUT without done: pulse err_timeout, go to S_FILL, out_valid stays 0.
  - If done and timeout occur in the same cycle, done wins.
  - done outside S_RUN is ignored.
- S_OUT:
  - out_valid=1 and out_data held until out_ready.
  - On out_valid && out_ready: out_valid<=0, go to S_FILL. in_ready rises the next cycle.
- Latency: the last input word is accepted at cycle t.
  - start is at t+1 if op_ready is already high.
  - out_valid rises the cycle after done.
- Reset mid-operation aborts any state to the reset values above. No error pulse is issued.
- Error pulses are registered, asserted the cycle after the causing event, for one cycle each.

Decomposition:
- Shared package holds:
  - State encoding: S_FILL=0, S_DRAIN=1, S_ISSUE=2, S_RUN=3, S_OUT=4.
  - Default DATA_W, NUM_OPS, TIMEOUT, so the controller, datapath and sequencer agree on word width and operand count.
- One natural sub-module: sched_watchdog (load/clear, enable, expire flag at TIMEOUT).
- Frame capture and the FSM stay in the top module.

Test Plan:
- Normal job (NUM_OPS=3): send 0x0003, 0x0005, 0x0007 (last on the 3rd), with op_ready=1. Required:
  - start is a single pulse the cycle after the 3rd word.
  - op_data={0x0007,0x0005,0x0003}.
  - done with result=0x0042 four cycles later gives out_valid=1 and out_data=0x0042 the next cycle.
  - out_ready=1 returns busy=0.
- Back-pressure: hold out_ready=0 for 10 cycles. out_valid and out_data=0x0042 stay stable and in_ready stays 0. Release: one transfer, then in_ready=1.
- Short frame: send 0x1111 with in_last on word 0. Required: err_frame pulse, no start. A following valid 3-word frame runs normally with the new operands.
- Long frame: send 4 words with last on the 4th. Required: err_frame after the 3rd word, the 4th is discarded, no start, op_data is not altered by the 4th word, and the FSM returns to S_FILL.
- Controller busy and timeout:
  - Hold op_ready=0 for 20 cycles: start stays 0.
  - Raise op_ready: start pulses once.
  - Never assert done: err_timeout pulses after TIMEOUT=64 cycles, out_valid stays 0, the FSM returns to S_FILL.
- Async reset asserted mid-S_RUN: outputs immediately at reset values. A later done pulse is ignored (no out_valid).
